// File: rtl/fe_capture_ctrl_pkg.sv
// Shared definitions for the front-end capture controller: FIFO record commands,
// timestamp field lengths and controller state encodings.
package fe_capture_ctrl_pkg;

    localparam int unsigned FE_FIFO_SHORTTIME_LEN = 3;
    localparam int unsigned FE_FIFO_FULLTIME_LEN  = 16;
    localparam int unsigned FE_CAPTURE_LEN_WIDTH  = 24;

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
    localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } fe_cap_state_e;

endpackage

// File: rtl/fe_capture_ctrl_if.sv
// Capture-controller bus: arm/event/command inputs from the formatter side and the
// registered FIFO write fields and status going back.
interface fe_capture_ctrl_if
    import fe_capture_ctrl_pkg::*;
#(
    parameter int unsigned pTIMESTAMP_FULL_WIDTH = FE_FIFO_FULLTIME_LEN,
    parameter int unsigned pCAPTURE_LEN_WIDTH    = FE_CAPTURE_LEN_WIDTH
);

    logic                             I_arm;
    logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len;
    logic                             I_event;
    logic [1:0]                       I_data_cmd;
    logic                             I_fifo_write_allowed;

    logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time;
    logic [1:0]                       O_fifo_command;
    logic                             O_fifo_wr;
    logic                             O_capturing;
    logic                             O_done;
    logic                             O_overflow;
    logic [pCAPTURE_LEN_WIDTH-1:0]    O_event_count;

    modport master (
        output I_arm, I_capture_len, I_event, I_data_cmd, I_fifo_write_allowed,
        input  O_fifo_time, O_fifo_command, O_fifo_wr, O_capturing, O_done, O_overflow,
               O_event_count
    );

    modport slave (
        input  I_arm, I_capture_len, I_event, I_data_cmd, I_fifo_write_allowed,
        output O_fifo_time, O_fifo_command, O_fifo_wr, O_capturing, O_done, O_overflow,
               O_event_count
    );

endinterface

// File: rtl/fe_timestamp_counter.sv
// Inter-event timestamp counter: load-1 on each issued record, saturating increment,
// plus the compares the controller needs for TIME record insertion.
module fe_timestamp_counter #(
    parameter int unsigned FullWidth  = 16,
    parameter int unsigned ShortWidth = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 load_one_i,
    input  logic                 inc_i,
    output logic [FullWidth-1:0] ts_o,
    output logic                 sat_o,
    output logic                 ge_short_o
);

    localparam logic [FullWidth-1:0] ShortMax = FullWidth'((1 << ShortWidth) - 1);

    logic [FullWidth-1:0] ts_q, ts_d;

    // Load-1 beats clear so the first issue after arming restarts timing at 1.
    always_comb begin
        ts_d = ts_q;
        if (load_one_i) begin
            ts_d = {{(FullWidth-1){1'b0}}, 1'b1};
        end else if (clear_i) begin
            ts_d = '0;
        end else if (inc_i && !sat_o) begin
            ts_d = ts_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign ts_o       = ts_q;
    assign sat_o      = &ts_q;
    assign ge_short_o = (ts_q >= ShortMax);

endmodule

// File: rtl/fe_capture_ctrl.sv
// Front-end capture controller: arms on I_arm, delays events two cycles to line up with
// the formatter's data pipeline, and issues DATA/STAT/TIME writes into the sniff FIFO.
module fe_capture_ctrl
    import fe_capture_ctrl_pkg::*;
#(
    parameter int unsigned pTIMESTAMP_FULL_WIDTH  = FE_FIFO_FULLTIME_LEN,
    parameter int unsigned pTIMESTAMP_SHORT_WIDTH = FE_FIFO_SHORTTIME_LEN,
    parameter int unsigned pCAPTURE_LEN_WIDTH     = FE_CAPTURE_LEN_WIDTH
) (
    input  logic              fe_clk,
    input  logic              reset_n,
    fe_capture_ctrl_if.slave  bus
);

    localparam int unsigned TsW  = pTIMESTAMP_FULL_WIDTH;
    localparam int unsigned ShW  = pTIMESTAMP_SHORT_WIDTH;
    localparam int unsigned LenW = pCAPTURE_LEN_WIDTH;

    fe_cap_state_e   state_q, state_d;
    logic            arm_q;
    logic            ev_d1_q, ev_d1_d;
    logic            ev_d2_q, ev_d2_d;
    logic            started_q, started_d;
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] cnt_q, cnt_d;
    logic [TsW-1:0]  time_q, time_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            wr_q, wr_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            capt_q, capt_d;

    logic [TsW-1:0]  ts;
    logic            ts_sat;
    logic            ts_ge_short;
    logic            ts_load_one;
    logic            ts_clear;
    logic            ts_inc;

    // ts stays at 0 until the first event of a capture has been issued.
    assign ts_clear = (state_q != StCapture);
    assign ts_inc   = started_q;

    fe_timestamp_counter #(
        .FullWidth  (TsW),
        .ShortWidth (ShW)
    ) u_ts (
        .clk_i      (fe_clk),
        .rst_ni     (reset_n),
        .clear_i    (ts_clear),
        .load_one_i (ts_load_one),
        .inc_i      (ts_inc),
        .ts_o       (ts),
        .sat_o      (ts_sat),
        .ge_short_o (ts_ge_short)
    );

    always_comb begin
        state_d     = state_q;
        ev_d1_d     = 1'b0;
        ev_d2_d     = 1'b0;
        started_d   = started_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        time_d      = time_q;
        cmd_d       = cmd_q;
        wr_d        = 1'b0;
        done_d      = 1'b0;
        ovf_d       = ovf_q | (wr_q & ~bus.I_fifo_write_allowed);
        ts_load_one = 1'b0;

        if (!bus.I_arm) begin
            // Dropping arm flushes the delay line and suppresses any write due now.
            state_d = StIdle;
            time_d  = '0;
            cmd_d   = FE_FIFO_CMD_DATA;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!arm_q) begin
                        state_d = StArmed;
                        len_d   = bus.I_capture_len;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                StArmed: begin
                    if (bus.I_event) begin
                        state_d = StCapture;
                        ev_d1_d = 1'b1;
                    end
                end
                StCapture: begin
                    ev_d1_d = bus.I_event;
                    ev_d2_d = ev_d1_q;
                    if (ev_d2_q) begin
                        wr_d             = 1'b1;
                        cmd_d            = bus.I_data_cmd;
                        time_d           = '0;
                        time_d[ShW-1:0]  = ts[ShW-1:0];
                        ts_load_one      = 1'b1;
                        started_d        = 1'b1;
                        cnt_d            = cnt_q + 1'b1;
                        if ((len_q != '0) && (cnt_d == len_q)) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                            ev_d1_d = 1'b0;
                            ev_d2_d = 1'b0;
                        end
                    end else if ((ev_d1_q && ts_ge_short) || ts_sat) begin
                        // Lookahead TIME record one cycle ahead of the event keeps the
                        // event's short time field in range without shifting it.
                        wr_d        = 1'b1;
                        cmd_d       = FE_FIFO_CMD_TIME;
                        time_d      = ts;
                        ts_load_one = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (state_d != StCapture) begin
            started_d = 1'b0;
        end
        capt_d = (state_d == StArmed) || (state_d == StCapture);
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            arm_q     <= 1'b0;
            ev_d1_q   <= 1'b0;
            ev_d2_q   <= 1'b0;
            started_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            time_q    <= '0;
            cmd_q     <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            capt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_q     <= bus.I_arm;
            ev_d1_q   <= ev_d1_d;
            ev_d2_q   <= ev_d2_d;
            started_q <= started_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            time_q    <= time_d;
            cmd_q     <= cmd_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            capt_q    <= capt_d;
        end
    end

    assign bus.O_fifo_time    = time_q;
    assign bus.O_fifo_command = cmd_q;
    assign bus.O_fifo_wr      = wr_q;
    assign bus.O_capturing    = capt_q;
    assign bus.O_done         = done_q;
    assign bus.O_overflow     = ovf_q;
    assign bus.O_event_count  = cnt_q;

endmodule

// File: tb/tb_fe_capture_ctrl.sv
// Self-checking bench for fe_capture_ctrl: vector table plus hand-written corner cases,
// with expected FIFO writes queued at stimulus time and popped when the DUT writes.
module tb_fe_capture_ctrl;
    import fe_capture_ctrl_pkg::*;

    typedef struct {
        int         off;
        logic [1:0] cmd;
        bit         pre;
        logic [15:0] pre_t;
        logic [15:0] dat_t;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [1:0]  cmd;
        logic [15:0] tm;
        logic        done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   base   = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    bit         ev_sched  [int];
    logic [1:0] cmd_sched [int];
    bit         blk_sched [int];
    exp_t       exp_q [$];
    vec_t       vecs [7];

    fe_capture_ctrl_if bus ();

    fe_capture_ctrl dut (
        .fe_clk  (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.I_event              = ev_sched.exists(cyc);
        bus.I_data_cmd           = cmd_sched.exists(cyc) ? cmd_sched[cyc] : 2'd0;
        bus.I_fifo_write_allowed = !blk_sched.exists(cyc);
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic arm_up(input logic [23:0] len);
        bus.I_arm = 1'b0;
        step();
        bus.I_capture_len = len;
        bus.I_arm         = 1'b1;
        base              = cyc;
        step();
    endtask

    task automatic sched_ev(input int off, input logic [1:0] cmd);
        ev_sched[base + off]      = 1'b1;
        cmd_sched[base + off + 2] = cmd;
    endtask

    task automatic expect_wr(input int off, input logic [1:0] cmd, input logic [15:0] tm,
                             input logic done);
        exp_t e;
        e.cyc  = base + off;
        e.cmd  = cmd;
        e.tm   = tm;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Scoreboard side: every DUT write must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.O_fifo_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_wr: got write cmd=%0d time=%0d at cycle %0d, required no write",
                             bus.O_fifo_command, bus.O_fifo_time, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wr_cmd", 64'(bus.O_fifo_command), 64'(e.cmd));
                    chk("wr_time", 64'(bus.O_fifo_time), 64'(e.tm));
                    chk("wr_done", 64'(bus.O_done), 64'(e.done));
                end
            end
        end
    end

    initial begin
        rst_n                    = 1'b0;
        bus.I_arm                = 1'b0;
        bus.I_capture_len        = '0;
        bus.I_event              = 1'b0;
        bus.I_data_cmd           = '0;
        bus.I_fifo_write_allowed = 1'b1;

        // Table rows: event offset from arming, command, expected lookahead TIME, data time.
        vecs[0] = '{10, FE_FIFO_CMD_DATA, 1'b0, 16'd0,  16'd0};
        vecs[1] = '{12, FE_FIFO_CMD_DATA, 1'b0, 16'd0,  16'd2};
        vecs[2] = '{32, FE_FIFO_CMD_STAT, 1'b1, 16'd19, 16'd1};
        vecs[3] = '{33, FE_FIFO_CMD_STAT, 1'b0, 16'd0,  16'd1};
        vecs[4] = '{40, FE_FIFO_CMD_STAT, 1'b0, 16'd0,  16'd7};
        vecs[5] = '{48, FE_FIFO_CMD_STAT, 1'b1, 16'd7,  16'd1};
        vecs[6] = '{60, FE_FIFO_CMD_DATA, 1'b1, 16'd11, 16'd1};

        repeat (3) step();
        chk("rst_wr", 64'(bus.O_fifo_wr), 0);
        chk("rst_time", 64'(bus.O_fifo_time), 0);
        chk("rst_cmd", 64'(bus.O_fifo_command), 0);
        chk("rst_capturing", 64'(bus.O_capturing), 0);
        chk("rst_done", 64'(bus.O_done), 0);
        chk("rst_overflow", 64'(bus.O_overflow), 0);
        chk("rst_count", 64'(bus.O_event_count), 0);
        rst_n = 1'b1;
        step();

        // Unlimited capture driven from the vector table.
        arm_up(24'd0);
        chk("t1_capturing", 64'(bus.O_capturing), 1);
        for (int i = 0; i < 7; i++) begin
            sched_ev(vecs[i].off, vecs[i].cmd);
            if (vecs[i].pre) expect_wr(vecs[i].off + 2, FE_FIFO_CMD_TIME, vecs[i].pre_t, 1'b0);
            expect_wr(vecs[i].off + 3, vecs[i].cmd, vecs[i].dat_t, 1'b0);
        end
        run_until(base + 70);
        chk("t1_drain", 64'(exp_q.size()), 0);
        chk("t1_count", 64'(bus.O_event_count), 7);
        chk("t1_overflow", 64'(bus.O_overflow), 0);
        bus.I_arm = 1'b0;
        step();
        step();
        chk("t1_off_capturing", 64'(bus.O_capturing), 0);
        chk("t1_off_time", 64'(bus.O_fifo_time), 0);
        chk("t1_off_cmd", 64'(bus.O_fifo_command), 0);

        // Length limit of 3 with five back-to-back events.
        arm_up(24'd3);
        for (int off = 5; off <= 9; off++) sched_ev(off, FE_FIFO_CMD_STAT);
        expect_wr(8, FE_FIFO_CMD_STAT, 16'd0, 1'b0);
        expect_wr(9, FE_FIFO_CMD_STAT, 16'd1, 1'b0);
        expect_wr(10, FE_FIFO_CMD_STAT, 16'd1, 1'b1);
        run_until(base + 14);
        chk("len_count", 64'(bus.O_event_count), 3);
        chk("len_capturing", 64'(bus.O_capturing), 0);
        chk("len_done_pulse", 64'(bus.O_done), 0);
        sched_ev(16, FE_FIFO_CMD_DATA);
        run_until(base + 25);
        chk("len_drain", 64'(exp_q.size()), 0);
        chk("len_count_hold", 64'(bus.O_event_count), 3);

        // FIFO full during the second of four writes.
        arm_up(24'd0);
        sched_ev(5, FE_FIFO_CMD_STAT);
        sched_ev(6, FE_FIFO_CMD_DATA);
        sched_ev(7, FE_FIFO_CMD_STAT);
        sched_ev(8, FE_FIFO_CMD_STAT);
        blk_sched[base + 9] = 1'b1;
        expect_wr(8, FE_FIFO_CMD_STAT, 16'd0, 1'b0);
        expect_wr(9, FE_FIFO_CMD_DATA, 16'd1, 1'b0);
        expect_wr(10, FE_FIFO_CMD_STAT, 16'd1, 1'b0);
        expect_wr(11, FE_FIFO_CMD_STAT, 16'd1, 1'b0);
        run_until(base + 9);
        chk("ovf_before", 64'(bus.O_overflow), 0);
        run_until(base + 15);
        chk("ovf_set", 64'(bus.O_overflow), 1);
        chk("ovf_count", 64'(bus.O_event_count), 4);
        chk("ovf_drain", 64'(exp_q.size()), 0);
        bus.I_arm = 1'b0;
        step();
        step();
        chk("ovf_sticky_idle", 64'(bus.O_overflow), 1);
        arm_up(24'd0);
        chk("ovf_cleared_rearm", 64'(bus.O_overflow), 0);

        // Arm dropped one cycle after an event, and exactly when its write is due.
        for (int k = 1; k <= 2; k++) begin
            arm_up(24'd0);
            sched_ev(5, FE_FIFO_CMD_STAT);
            run_until(base + 5 + k);
            bus.I_arm = 1'b0;
            run_until(base + 12);
            chk("armdrop_capturing", 64'(bus.O_capturing), 0);
            chk("armdrop_count", 64'(bus.O_event_count), 0);
            chk("armdrop_cmd", 64'(bus.O_fifo_command), 0);
        end

        // Reset pulse one cycle after an event.
        arm_up(24'd0);
        sched_ev(5, FE_FIFO_CMD_STAT);
        expect_wr(8, FE_FIFO_CMD_STAT, 16'd0, 1'b0);
        sched_ev(12, FE_FIFO_CMD_STAT);
        run_until(base + 13);
        chk("prereset_cmd", 64'(bus.O_fifo_command), 64'(FE_FIFO_CMD_STAT));
        rst_n = 1'b0;
        #1;
        chk("midrst_capturing", 64'(bus.O_capturing), 0);
        chk("midrst_count", 64'(bus.O_event_count), 0);
        chk("midrst_cmd", 64'(bus.O_fifo_command), 0);
        chk("midrst_wr", 64'(bus.O_fifo_wr), 0);
        bus.I_arm = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        run_until(base + 22);
        chk("postrst_capturing", 64'(bus.O_capturing), 0);
        chk("postrst_drain", 64'(exp_q.size()), 0);

        // One event then a long idle: a saturated TIME record 65535 cycles after it.
        arm_up(24'd0);
        sched_ev(5, FE_FIFO_CMD_DATA);
        expect_wr(8, FE_FIFO_CMD_DATA, 16'd0, 1'b0);
        expect_wr(8 + 65535, FE_FIFO_CMD_TIME, 16'd65535, 1'b0);
        run_until(base + 70005);
        chk("long_drain", 64'(exp_q.size()), 0);
        chk("long_count", 64'(bus.O_event_count), 1);
        chk("long_capturing", 64'(bus.O_capturing), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
